lfsr_cipher_engine: RTL

- Hardware replacement for the software message encryptor (Program 1), extended to decrypt as well.
- Encrypt mode reads a raw ASCII message from data memory, pads it with a pre-length of spaces and trailing spaces, XORs each character with a maximal-length LFSR stream, inserts a parity MSB and writes the full frame back to memory.
- Decrypt mode reverses the XOR on a ciphertext frame and counts parity errors.
- Sits beside DM1 in TopLevel; uses the same Start/Ack launch protocol as the processor core.

---
 rtl/lfsr_cipher_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lfsr_cipher_engine.sv
// LFSR stream cipher engine: encrypts a padded message frame with parity
// insertion, or decrypts a ciphertext frame and counts parity failures.
// One character per cycle against an asynchronous-read memory.
module lfsr_cipher_engine #(
  parameter int unsigned      DW       = 8,
  parameter int unsigned      LW       = 7,
  parameter int unsigned      FRAME    = 64,
  parameter int unsigned      MSG_MAX  = 49,
  parameter int unsigned      PRE_MIN  = 10,
  parameter int unsigned      PRE_MAX  = 15,
  parameter int unsigned      SRC_BASE = 0,
  parameter int unsigned      DST_BASE = 64,
  parameter logic [DW-1:0]    PAD_CHAR = 8'h20,
  parameter int unsigned      AW       = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Ack,
  input  logic          mode,
  input  logic [7:0]    cfg_pre_len,
  input  logic [7:0]    cfg_msg_len,
  input  logic [LW-1:0] cfg_taps,
  input  logic [LW-1:0] cfg_init,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [6:0]    par_err_cnt,
  output logic          busy
);

  // state  | meaning
  // IDLE   | waiting for Start low
  // INIT   | latch config, clamp lengths, seed LFSR
  // RUN    | one character per cycle, FRAME cycles
  // DONE   | Ack high until Start goes high
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t        state;
  logic          mode_q;
  logic [LW-1:0] taps_q;
  logic [LW-1:0] lfsr;
  logic [7:0]    pre_q;
  logic [7:0]    len_q;
  logic [7:0]    idx;

  logic [7:0]    pre_clamped;
  logic [7:0]    len_clipped;
  logic          in_msg;
  logic [7:0]    msg_off;
  logic [DW-1:0] src;
  logic [LW-1:0] x;

  // Configuration clamping applied when INIT latches the run parameters.
  always_comb begin
    if (cfg_pre_len < 8'(PRE_MIN))      pre_clamped = 8'(PRE_MIN);
    else if (cfg_pre_len > 8'(PRE_MAX)) pre_clamped = 8'(PRE_MAX);
    else                                pre_clamped = cfg_pre_len;
    len_clipped = (cfg_msg_len > 8'(MSG_MAX)) ? 8'(MSG_MAX) : cfg_msg_len;
  end

  assign in_msg  = (idx >= pre_q) && (idx < pre_q + len_q);
  assign msg_off = idx - pre_q;

  // Read/modify/write datapath: the read is async, so the write of the same
  // character happens in the same cycle. Reset gates the strobe at once.
  always_comb begin
    src     = PAD_CHAR;
    x       = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state == S_RUN) begin
      if (mode_q) begin
        rd_addr = AW'(SRC_BASE) + AW'(idx);
        src     = rd_data;
      end else if (in_msg) begin
        rd_addr = AW'(SRC_BASE) + AW'(msg_off);
        src     = rd_data;
      end
      x       = src[LW-1:0] ^ lfsr;
      wr_en   = !Reset;
      wr_addr = AW'(DST_BASE) + AW'(idx);
      wr_data = mode_q ? {1'b0, x} : {^x, x};
    end
  end

  // Sequencer with registered Ack/busy and the parity error counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      Ack         <= 1'b0;
      busy        <= 1'b0;
      par_err_cnt <= '0;
      mode_q      <= 1'b0;
      taps_q      <= '0;
      lfsr        <= LW'(1);
      pre_q       <= '0;
      len_q       <= '0;
      idx         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          Ack <= 1'b0;
          if (!Start) begin
            state <= S_INIT;
            busy  <= 1'b1;
          end
        end
        S_INIT: begin
          if (Start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            mode_q      <= mode;
            taps_q      <= cfg_taps;
            pre_q       <= pre_clamped;
            len_q       <= len_clipped;
            lfsr        <= (cfg_init == '0) ? LW'(1) : cfg_init;
            idx         <= '0;
            par_err_cnt <= '0;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (Start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            lfsr <= {lfsr[LW-2:0], ^(lfsr & taps_q)};
            idx  <= idx + 8'd1;
            if (mode_q && (^src) && (par_err_cnt != 7'h7f))
              par_err_cnt <= par_err_cnt + 7'd1;
            if (idx == 8'(FRAME - 1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              Ack   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (Start) begin
            state <= S_IDLE;
            Ack   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
